// File: rtl/cpu_arb_pkg.sv
// Shared defaults and helper functions for the register-bank write arbiter.
// Helpers work on an 8-bit requester vector so they cover every legal NREQ (2..8).
package cpu_arb_pkg;

    localparam int unsigned NREQ_DEF     = 4;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned ADDR_W_DEF   = 3;
    localparam int unsigned LOCK_MAX_DEF = 4;
    localparam int unsigned NREQ_MAX     = 8;

    typedef logic [NREQ_MAX-1:0] req_vec_t;
    typedef logic [2:0]          req_idx_t;

    function automatic req_idx_t onehot2idx(input req_vec_t oh);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < int'(NREQ_MAX); i++) begin
            if (oh[i]) idx = req_idx_t'(i);
        end
        return idx;
    endfunction

    // Scans ptr, ptr+1, ... mod n; iterating backwards lets the nearest requester win.
    function automatic req_vec_t rr_pick(input req_vec_t req, input req_idx_t ptr, input int n);
        req_vec_t oh;
        int       idx;
        oh = '0;
        for (int k = int'(NREQ_MAX) - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx]) begin
                    oh      = '0;
                    oh[idx] = 1'b1;
                end
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin write arbiter: combinational one-hot grant plus rotating pointer.
// Define ARB_LOCK_EN to let a granted requester hold the grant for up to LOCK_MAX cycles.
module rr_arbiter_core
    import cpu_arb_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEF,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF,
    localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  req_lock,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] scan_ptr;
    logic [NREQ-1:0]  gnt_c;
    logic [IDX_W-1:0] gnt_idx_c;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == int'(NREQ) - 1) ? IDX_W'(0) : i + 1'b1;
    endfunction

`ifdef ARB_LOCK_EN
    logic             lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0] lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] new_cnt;
`else
    logic [CNT_W:0]   unused_lock;
    assign unused_lock = {(CNT_W + 1){^req_lock}};
`endif

    always_comb begin
        rr_ptr_d = rr_ptr_q;
`ifdef ARB_LOCK_EN
        lock_vld_d   = 1'b0;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = '0;
        new_cnt      = '0;
        // Once a lock lapses because its owner went idle, resume scanning just past the owner.
        scan_ptr     = lock_vld_q ? next_idx(lock_owner_q) : rr_ptr_q;
`else
        scan_ptr     = rr_ptr_q;
`endif
        gnt_c = NREQ'(rr_pick(req_vec_t'(req), req_idx_t'(scan_ptr), int'(NREQ)));
`ifdef ARB_LOCK_EN
        if (lock_vld_q && req[lock_owner_q]) begin
            gnt_c               = '0;
            gnt_c[lock_owner_q] = 1'b1;
        end
`endif
        if (!reset_n) gnt_c = '0;
        gnt_idx_c = IDX_W'(onehot2idx(req_vec_t'(gnt_c)));

        if (|gnt_c) begin
            rr_ptr_d = next_idx(gnt_idx_c);
`ifdef ARB_LOCK_EN
            if (req_lock[gnt_idx_c]) begin
                new_cnt = (lock_vld_q && lock_owner_q == gnt_idx_c) ? lock_cnt_q + 1'b1
                                                                     : CNT_W'(1);
                if (new_cnt < CNT_W'(LOCK_MAX)) begin
                    lock_vld_d   = 1'b1;
                    lock_owner_d = gnt_idx_c;
                    lock_cnt_d   = new_cnt;
                    rr_ptr_d     = rr_ptr_q;
                end
            end
`endif
        end else begin
            rr_ptr_d = scan_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q     <= '0;
`ifdef ARB_LOCK_EN
            lock_vld_q   <= 1'b0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
`endif
        end else begin
            rr_ptr_q     <= rr_ptr_d;
`ifdef ARB_LOCK_EN
            lock_vld_q   <= lock_vld_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
`endif
        end
    end

    assign gnt     = gnt_c;
    assign gnt_idx = gnt_idx_c;

endmodule

// File: rtl/regbank_write_arbiter.sv
// Register bank shared by NREQ writers through rr_arbiter_core; one combinational read port.
// ARB_LOCK_EN (passed through to the core) enables locked back-to-back grants.
module regbank_write_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_lock,
    output logic [NREQ-1:0]          gnt,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [DATA_W-1:0] bank_q [DEPTH];
    logic [IDX_W-1:0]  gnt_idx;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    rr_arbiter_core #(
        .NREQ     (NREQ),
        .LOCK_MAX (LOCK_MAX)
    ) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_lock (req_lock),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    assign wr_addr = req_addr[int'(gnt_idx) * ADDR_W +: ADDR_W];
    assign wr_data = req_data[int'(gnt_idx) * DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) bank_q[i] <= '0;
        end else if (|gnt) begin
            bank_q[wr_addr] <= wr_data;
        end
    end

    // No write-to-read bypass: new data appears the cycle after the write edge.
    assign rd_data = bank_q[rd_addr];
    assign busy    = |req;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter; inputs change on the falling edge, outputs are
// sampled 1 time unit later. The lock scenario expects locked grants when ARB_LOCK_EN is defined.
module tb_regbank_write_arbiter;

    localparam int NREQ     = 4;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int LOCK_MAX = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ-1:0]        gnt;
    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regbank_write_arbiter #(
        .NREQ     (NREQ),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_lock (req_lock),
        .gnt      (gnt),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req[i] = 1'b1;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        reset_n  = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        req_lock = '0;
        rd_addr  = '0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        set_req(0, 3'd2, 8'hA5);
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL gnt_in_reset: got %b, expected %b", gnt, 4'b0000);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL gnt_after_release: got %b, expected %b", gnt, 4'b0001);
        end
        @(negedge clk);
        req = '0;
        rd_addr = 3'd2;
        set_req(0, 3'd2, 8'h5A);
        #1;
        checks++;
        if (rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL write_before_reset: got %h, expected %h", rd_data, 8'hA5);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL gnt_async_reset: got %b, expected %b", gnt, 4'b0000);
        end
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL bank_async_reset: got %h, expected %h", rd_data, 8'h00);
        end
        req = '0;
        #1 reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL bank_after_reset: got %h, expected %h", rd_data, 8'h00);
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        set_req(0, 3'd5, 8'h3C);
        rd_addr = 3'd5;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_gnt: got %b, expected %b", gnt, 4'b0001);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_high: got %b, expected %b", busy, 1'b1);
        end
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL no_bypass: got %h, expected %h", rd_data, 8'h00);
        end
        @(negedge clk);
        req = '0;
        #1;
        checks++;
        if (rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL single_data: got %h, expected %h", rd_data, 8'h3C);
        end
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_gnt_busy: got %b/%b, expected %b/%b", gnt, busy, 4'b0000, 1'b0);
        end
        // Pointer now at 1: with everyone asking, requester 1 must win.
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, 3'd6, DATA_W'(i));
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL ptr_after_single: got %b, expected %b", gnt, 4'b0010);
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] exp_gnt;
        set_req(3, 3'd6, 8'h33);
        #1;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL contention_setup: got %b, expected %b", gnt, 4'b1000);
        end
        @(negedge clk);
        req = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(i), DATA_W'(8'h40 + i));
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_gnt = '0;
            exp_gnt[c % NREQ] = 1'b1;
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("FAIL contention_cycle%0d: got %b, expected %b", c, gnt, exp_gnt);
            end
        end
        @(negedge clk);
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            rd_addr = ADDR_W'(i);
            #1;
            checks++;
            if (rd_data !== DATA_W'(8'h40 + i)) begin
                errors++;
                $display("FAIL contention_bank%0d: got %h, expected %h", i, rd_data, DATA_W'(8'h40 + i));
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        req = '0;
        set_req(2, 3'd1, 8'h77);
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_setup: got %b, expected %b", gnt, 4'b0100);
        end
        @(negedge clk);
        req = '0;
        set_req(0, 3'd0, 8'h50);
        set_req(3, 3'd3, 8'h53);
        #1;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first: got %b, expected %b", gnt, 4'b1000);
        end
        @(negedge clk);
        rd_addr = 3'd3;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_second: got %b, expected %b", gnt, 4'b0001);
        end
        checks++;
        if (rd_data !== 8'h53) begin
            errors++;
            $display("FAIL wrap_data3: got %h, expected %h", rd_data, 8'h53);
        end
        @(negedge clk);
        req = '0;
        rd_addr = 3'd0;
        #1;
        checks++;
        if (rd_data !== 8'h50) begin
            errors++;
            $display("FAIL wrap_data0: got %h, expected %h", rd_data, 8'h50);
        end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        set_req(3, 3'd6, 8'h66);
        #1;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL conflict_setup: got %b, expected %b", gnt, 4'b1000);
        end
        @(negedge clk);
        req = '0;
        set_req(0, 3'd7, 8'h11);
        set_req(2, 3'd7, 8'h22);
        rd_addr = 3'd7;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL conflict_gnt0: got %b, expected %b", gnt, 4'b0001);
        end
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL conflict_gnt2: got %b, expected %b", gnt, 4'b0100);
        end
        checks++;
        if (rd_data !== 8'h11) begin
            errors++;
            $display("FAIL conflict_first: got %h, expected %h", rd_data, 8'h11);
        end
        @(negedge clk);
        req = '0;
        #1;
        checks++;
        if (rd_data !== 8'h22) begin
            errors++;
            $display("FAIL conflict_final: got %h, expected %h", rd_data, 8'h22);
        end
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] exp_seq [5];
`ifdef ARB_LOCK_EN
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
        @(negedge clk);
        set_req(0, 3'd4, 8'hA0);
        set_req(1, 3'd5, 8'hB1);
        req_lock = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++;
            if (gnt !== exp_seq[c]) begin
                errors++;
                $display("FAIL lock_cycle%0d: got %b, expected %b", c, gnt, exp_seq[c]);
            end
        end
        @(negedge clk);
        req = '0;
        req_lock = '0;
        rd_addr = 3'd4;
        #1;
        checks++;
        if (rd_data !== 8'hA0) begin
            errors++;
            $display("FAIL lock_data0: got %h, expected %h", rd_data, 8'hA0);
        end
        rd_addr = 3'd5;
        #1;
        checks++;
        if (rd_data !== 8'hB1) begin
            errors++;
            $display("FAIL lock_data1: got %h, expected %h", rd_data, 8'hB1);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_wrap();
        test_conflict();
        test_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
